// File: rtl/instr_inv_queue_pkg.sv
// Shared types for the instruction-side invalidation queue: CPU configuration,
// the queued request type and the line-address width helper.
package instr_inv_queue_pkg;

    typedef struct packed {
        int unsigned INSTR_INV_QUEUE_DEPTH;
    } cpu_config_t;

    localparam cpu_config_t CPU_CFG_DEFAULT = '{INSTR_INV_QUEUE_DEPTH: 32'd4};

    typedef struct packed {
        logic [31:0] addr;
    } inv_req_t;

    // Width of addr[31:2+log2(line_w)], the part compared when coalescing.
    function automatic int line_addr_w(input int line_w);
        return 30 - $clog2(line_w);
    endfunction

endpackage

// File: rtl/instr_inv_queue_if.sv
// Producer and consumer signals of the invalidation queue. The slave modport is
// the queue itself; the master modport is the data side plus icache/predictor.
interface instr_inv_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             inv_valid;
    logic [31:0]      inv_addr;
    logic             inv_ready;
    logic             ic_inv_valid;
    logic [31:0]      ic_inv_addr;
    logic             ic_inv_ack;
    logic             bp_inv_valid;
    logic [31:0]      bp_inv_addr;
    logic             bp_inv_ack;
    logic             empty;
    logic [CNT_W-1:0] count;

    modport slave (
        input  inv_valid, inv_addr, ic_inv_ack, bp_inv_ack,
        output inv_ready, ic_inv_valid, ic_inv_addr, bp_inv_valid, bp_inv_addr,
               empty, count
    );

    modport master (
        output inv_valid, inv_addr, ic_inv_ack, bp_inv_ack,
        input  inv_ready, ic_inv_valid, ic_inv_addr, bp_inv_valid, bp_inv_addr,
               empty, count
    );
endinterface

// File: rtl/instr_inv_fifo.sv
// Storage and pointers for the invalidation queue. Reads are asynchronous so a
// pushed entry reaches the head one cycle after the write.
module instr_inv_fifo
    import instr_inv_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  inv_req_t         wr_data,
    input  logic             rd_en,
    output inv_req_t         head_data,
    output inv_req_t         tail_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    inv_req_t         mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] tail_ptr;

    // Pointer and occupancy updates; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        count_next = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    // Pointer/count registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    assign tail_ptr  = wr_ptr_reg - PTR_W'(1);
    assign head_data = mem_reg[rd_ptr_reg];
    assign tail_data = mem_reg[tail_ptr];
    assign count     = count_reg;
endmodule

// File: rtl/instr_inv_queue.sv
// Invalidation queue between the data side and the instruction cache / branch
// predictor. Each head entry must be acknowledged by both consumers, in any
// order, before it pops. Pushes to the tail's cache line are merged.
module instr_inv_queue
    import instr_inv_queue_pkg::*;
#(
    parameter int DEPTH  = CPU_CFG_DEFAULT.INSTR_INV_QUEUE_DEPTH,
    parameter int LINE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_inv_queue_if.slave   bus
);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int LINE_AW  = line_addr_w(LINE_W);
    localparam int LINE_LSB = 32 - LINE_AW;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic             ic_done_reg, ic_done_next;
    logic             bp_done_reg, bp_done_next;
    logic             ready_reg, ready_next;
    inv_req_t         head_data, tail_data, wr_data;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             empty;
    logic             ic_valid, bp_valid;
    logic             ic_ack_eff, bp_ack_eff;
    logic             push, pop, coalesce, alloc;
    logic             tail_is_head, line_match, head_busy;

    assign wr_data.addr = bus.inv_addr;

    instr_inv_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (alloc),
        .wr_data   (wr_data),
        .rd_en     (pop),
        .head_data (head_data),
        .tail_data (tail_data),
        .count     (count)
    );

    assign empty    = (count == '0);
    assign ic_valid = !empty && !ic_done_reg;
    assign bp_valid = !empty && !bp_done_reg;

    // Handshake decode: acks only count while the matching valid is offered;
    // merging into the head is blocked once either consumer has touched it.
    always_comb begin
        ic_ack_eff   = bus.ic_inv_ack && ic_valid;
        bp_ack_eff   = bus.bp_inv_ack && bp_valid;
        pop          = !empty && (ic_done_reg || ic_ack_eff) && (bp_done_reg || bp_ack_eff);
        push         = bus.inv_valid && ready_reg;
        tail_is_head = (count == ONE_CNT);
        line_match   = (tail_data.addr[31:LINE_LSB] == bus.inv_addr[31:LINE_LSB]);
        head_busy    = ic_done_reg || bp_done_reg || bus.ic_inv_ack || bus.bp_inv_ack;
        coalesce     = push && !empty && line_match && !(tail_is_head && head_busy);
        alloc        = push && !coalesce;
        count_next   = count + CNT_W'(alloc) - CNT_W'(pop);
        ready_next   = (count_next != FULL_CNT);
    end

    // Done-bit next state: set by a lone ack, cleared whenever the head pops.
    always_comb begin
        ic_done_next = ic_done_reg;
        bp_done_next = bp_done_reg;
        if (pop) begin
            ic_done_next = 1'b0;
            bp_done_next = 1'b0;
        end else begin
            if (ic_ack_eff) begin
                ic_done_next = 1'b1;
            end
            if (bp_ack_eff) begin
                bp_done_next = 1'b1;
            end
        end
    end

    // Done bits and registered not-full ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ic_done_reg <= 1'b0;
            bp_done_reg <= 1'b0;
            ready_reg   <= 1'b1;
        end else begin
            ic_done_reg <= ic_done_next;
            bp_done_reg <= bp_done_next;
            ready_reg   <= ready_next;
        end
    end

    assign bus.inv_ready    = ready_reg;
    assign bus.ic_inv_valid = ic_valid;
    assign bus.bp_inv_valid = bp_valid;
    assign bus.ic_inv_addr  = head_data.addr;
    assign bus.bp_inv_addr  = head_data.addr;
    assign bus.empty        = empty;
    assign bus.count        = count;
endmodule
